scan_collector: RTL and testbench

//  Receiving end of the scanner flush protocol. Watches rdy_flush/mem_used from two

---
 rtl/scan_pkg.sv | 32 +++
 rtl/scan_collector_if.sv | 27 ++
 rtl/collector_fifo.sv | 52 +++++
 rtl/scan_collector.sv | 109 ++++++++++
 tb/tb_scan_collector.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared types for the scanner flush protocol: collector FSM codes, scanner state codes
// and the two-way round-robin helpers.
package scan_pkg;

  typedef enum logic [1:0] {
    COL_IDLE  = 2'b00,
    COL_FLUSH = 2'b01,
    COL_ABORT = 2'b10
  } collector_state_t;

  // Scanner-side state codes; the scanner's IDLE is prefixed to avoid clashing with COL_IDLE
  typedef enum logic [2:0] {
    LOW_PWR  = 3'b000,
    STBY     = 3'b001,
    SCANNING = 3'b010,
    SCN_IDLE = 3'b011,
    FLUSHING = 3'b100
  } scanner_state_t;

  localparam logic [7:0] MEM_FULL = 8'd100;

  function automatic logic [1:0] grant_onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

  // Single request wins outright; a tie goes to the scanner the pointer favours
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) return ptr;
    return req[1];
  endfunction

endpackage

// File: rtl/scan_collector_if.sv
// Scanner-side and uplink-side signals of the collector, bundled for port connection.
interface scan_collector_if #(
  parameter int unsigned DATA_W = 8
);
  logic [1:0]        rdy_flush;
  logic [7:0]        mem_used_0;
  logic [7:0]        mem_used_1;
  logic [1:0]        flush;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              up_valid;
  logic [DATA_W:0]   up_data;
  logic              up_ready;
  logic              flush_err;
  logic [1:0]        state;

  modport master (
    output rdy_flush, mem_used_0, mem_used_1, rx_valid, rx_data, up_ready,
    input  flush, rx_ready, up_valid, up_data, flush_err, state
  );

  modport slave (
    input  rdy_flush, mem_used_0, mem_used_1, rx_valid, rx_data, up_ready,
    output flush, rx_ready, up_valid, up_data, flush_err, state
  );
endinterface

// File: rtl/collector_fifo.sv
// First-word-fall-through FIFO holding tagged flush beats; async reset empties it.
module collector_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & (~full | pop);
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly AW bits, so the increment wraps modulo DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scan_collector.sv
// Flush collector: round-robin grant between two scanners, beat intake with idle timeout,
// and FWFT buffering of {src, data} towards the uplink.
module scan_collector
  import scan_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic             clk,
  input logic             reset,
  scan_collector_if.slave bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  collector_state_t state_q, state_nxt;
  logic             grant_src, grant_nxt;
  logic             rr_ptr, rr_nxt;
  logic [CW-1:0]    tmo_cnt, tmo_nxt;
  logic [1:0]       flush_q;
  logic             flush_err_q;

  logic             rx_ready;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       mem_sel;
  logic             pick;

  assign mem_sel = grant_src ? bus.mem_used_1 : bus.mem_used_0;
  assign pick    = rr_pick(bus.rdy_flush, rr_ptr);

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_src;
    rr_nxt    = rr_ptr;
    tmo_nxt   = tmo_cnt;
    rx_ready  = 1'b0;
    push      = 1'b0;
    case (state_q)
      COL_IDLE: begin
        if (|bus.rdy_flush) begin
          grant_nxt = pick;
          rr_nxt    = ~pick;
          tmo_nxt   = '0;
          state_nxt = COL_FLUSH;
        end
      end
      COL_FLUSH: begin
        rx_ready = ~fifo_full;
        push     = bus.rx_valid & ~fifo_full;
        // Counter only advances while the collector is actually waiting on the scanner
        if (push) begin
          tmo_nxt = '0;
        end else if (rx_ready) begin
          if (tmo_cnt == TMO_LAST) state_nxt = COL_ABORT;
          else                     tmo_nxt   = tmo_cnt + 1'b1;
        end
        // An empty scanner ends the transfer normally, even on the timeout cycle
        if (mem_sel == 8'd0) state_nxt = COL_IDLE;
      end
      COL_ABORT: state_nxt = COL_IDLE;
      default:   state_nxt = COL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COL_IDLE;
      grant_src   <= 1'b0;
      rr_ptr      <= 1'b0;
      tmo_cnt     <= '0;
      flush_q     <= '0;
      flush_err_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      grant_src   <= grant_nxt;
      rr_ptr      <= rr_nxt;
      tmo_cnt     <= tmo_nxt;
      flush_q     <= (state_nxt == COL_FLUSH) ? grant_onehot(grant_nxt) : 2'b00;
      flush_err_q <= (state_nxt == COL_ABORT);
    end
  end

  assign pop = ~fifo_empty & bus.up_ready;

  collector_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({grant_src, bus.rx_data}),
    .pop       (pop),
    .pop_data  (bus.up_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.flush     = flush_q;
  assign bus.flush_err = flush_err_q;
  assign bus.rx_ready  = rx_ready;
  assign bus.up_valid  = ~fifo_empty;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_scan_collector.sv
// Scoreboard bench for scan_collector: accepted beats queue their expected {src,data},
// uplink pops compare against the queue head.
module tb_scan_collector;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   err_cnt;
  logic exp_src;
  logic [8:0] sb [$];

  scan_collector_if #(.DATA_W(8)) bus ();

  scan_collector #(
    .DATA_W     (8),
    .FIFO_DEPTH (16),
    .TIMEOUT    (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pop-compare before push so same-cycle traffic keeps order
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.flush_err) err_cnt++;
      if (bus.up_valid && bus.up_ready) begin
        if (sb.size() == 0) check("sb_underrun", 32'(sb.size()), 32'd1);
        else                check("up_data", 32'(bus.up_data), 32'(sb.pop_front()));
      end
      if (bus.rx_valid && bus.rx_ready) sb.push_back({exp_src, bus.rx_data});
    end
  end

  task automatic wait_state(input string tag, input logic [1:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.state !== exp && n < 50);
    check(tag, 32'(bus.state), 32'(exp));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
    @(negedge clk);
    check({tag, "_uv"}, 32'(bus.up_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    int err_base;
    logic [1:0] exp_g;
    total = 0; bad = 0; err_cnt = 0; exp_src = 1'b0;
    reset = 1'b1;
    bus.rdy_flush = 2'b00; bus.mem_used_0 = 8'd0; bus.mem_used_1 = 8'd0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.up_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(bus.state), 32'h0);
    check("rst_flush", 32'(bus.flush), 32'h0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'h0);
    check("rst_up_valid", 32'(bus.up_valid), 32'h0);
    check("rst_flush_err", 32'(bus.flush_err), 32'h0);

    // Mid-sim async reset, sampled between clock edges
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 check("arst_state", 32'(bus.state), 32'h0);
    check("arst_flush", 32'(bus.flush), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_stay_idle", 32'(bus.state), 32'h0);

    // Single primary transfer A1..A3
    @(posedge clk);
    #1 bus.mem_used_0 = 8'd3; bus.rdy_flush = 2'b01; exp_src = 1'b0;
    @(negedge clk);
    check("t2_pre_flush", 32'(bus.flush), 32'h0);
    @(negedge clk);
    check("t2_flush", 32'(bus.flush), 32'h1);
    check("t2_state", 32'(bus.state), 32'h1);
    @(posedge clk);
    #1 bus.rdy_flush = 2'b00;
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hA1 + 8'(i);
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0; bus.mem_used_0 = 8'd0;
    @(negedge clk);
    check("t2_hold_flush", 32'(bus.flush), 32'h1);
    @(negedge clk);
    check("t2_end_flush", 32'(bus.flush), 32'h0);
    check("t2_end_state", 32'(bus.state), 32'h0);
    drain("t2_drain");

    // Both requesting from reset: grants alternate with one IDLE cycle between
    reset = 1'b1;
    sb.delete();
    bus.rdy_flush = 2'b11; bus.mem_used_0 = 8'd5; bus.mem_used_1 = 8'd5;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      check("t3_grant", 32'(bus.flush), 32'(exp_g));
      @(posedge clk);
      #1 if (exp_g == 2'b01) bus.mem_used_0 = 8'd0; else bus.mem_used_1 = 8'd0;
      @(posedge clk);
      #1 bus.mem_used_0 = 8'd5; bus.mem_used_1 = 8'd5;
      @(negedge clk);
      check("t3_gap_flush", 32'(bus.flush), 32'h0);
      check("t3_gap_state", 32'(bus.state), 32'h0);
    end
    bus.rdy_flush = 2'b00;

    // Fill to full with uplink stalled; timeout must stay frozen
    pulse_reset();
    bus.up_ready = 1'b0; bus.mem_used_0 = 8'd50; bus.rdy_flush = 2'b01; exp_src = 1'b0;
    wait_state("t4_enter", 2'b01);
    @(posedge clk);
    #1 bus.rdy_flush = 2'b00;
    for (int i = 0; i < 16; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'h10 + 8'(i);
      @(negedge clk);
      check("t4_fill_rdy", 32'(bus.rx_ready), 32'h1);
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("t4_full_rdy", 32'(bus.rx_ready), 32'h0);
    check("t4_sb_cnt", 32'(sb.size()), 32'd16);
    err_base = err_cnt;
    repeat (100) @(negedge clk);
    check("t4_no_err", 32'(err_cnt - err_base), 32'd0);
    check("t4_still_flush", 32'(bus.state), 32'h1);
    @(posedge clk);
    #1 bus.up_ready = 1'b1;
    @(negedge clk);
    check("t4_first_pop_rdy", 32'(bus.rx_ready), 32'h0);
    @(negedge clk);
    check("t4_resume_rdy", 32'(bus.rx_ready), 32'h1);
    @(posedge clk);
    #1 bus.mem_used_0 = 8'd0;
    drain("t4_drain");
    check("t4_idle", 32'(bus.state), 32'h0);

    // Idle scanner: abort after TIMEOUT cycles without a beat
    @(posedge clk);
    #1 bus.mem_used_0 = 8'd7; bus.rdy_flush = 2'b01;
    err_base = err_cnt;
    wait_state("t5_enter", 2'b01);
    bus.rdy_flush = 2'b00;
    n = 0;
    while (bus.flush_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_cycles", 32'(n), 32'd64);
    check("t5_abort_state", 32'(bus.state), 32'h2);
    check("t5_abort_flush", 32'(bus.flush), 32'h0);
    @(negedge clk);
    check("t5_back_idle", 32'(bus.state), 32'h0);
    check("t5_err_low", 32'(bus.flush_err), 32'h0);
    repeat (3) @(negedge clk);
    check("t5_err_once", 32'(err_cnt - err_base), 32'd1);

    // Async reset mid-transfer discards buffered beats
    bus.mem_used_0 = 8'd9; bus.up_ready = 1'b0; bus.rdy_flush = 2'b01; exp_src = 1'b0;
    wait_state("t6_enter", 2'b01);
    bus.rdy_flush = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 bus.rx_valid = 1'b1; bus.rx_data = 8'hC0 + 8'(i);
    end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    @(negedge clk);
    check("t6_up_valid_pre", 32'(bus.up_valid), 32'h1);
    check("t6_sb_cnt", 32'(sb.size()), 32'd5);
    #2 reset = 1'b1;
    #1 check("t6_flush", 32'(bus.flush), 32'h0);
    check("t6_up_valid", 32'(bus.up_valid), 32'h0);
    check("t6_rx_ready", 32'(bus.rx_ready), 32'h0);
    check("t6_state", 32'(bus.state), 32'h0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0; bus.up_ready = 1'b1; bus.mem_used_0 = 8'd0;
    repeat (3) @(negedge clk);
    check("t6_stay_idle", 32'(bus.state), 32'h0);
    check("t6_stay_empty", 32'(bus.up_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
